// File: rtl/vdma_burst_sched.sv
// Burst scheduler for one VDMA frame: splits each line into full AXI bursts plus an
// optional short tail, keeps one burst outstanding, and steps the address generator.
module vdma_burst_sched #(
  parameter int ASIZE       = 29,
  parameter int LSIZE       = 16,
  parameter int BURST_LEN   = 256,
  parameter int ADDR_SETTLE = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LSIZE-1:0] line_beats,
  input  logic [LSIZE-1:0] line_num,
  input  logic [ASIZE-1:0] addr_in,
  output logic             new_base,
  output logic             burst_done,
  output logic             tail_done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [ASIZE-1:0] cmd_addr,
  output logic [7:0]       cmd_len,
  input  logic             burst_resp_done,
  output logic             frame_done,
  output logic             busy
);

  localparam int BL_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW   = (ADDR_SETTLE > 0) ? $clog2(ADDR_SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(ADDR_SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_ISSUE, S_WAIT, S_ADV, S_FEND
  } state_t;

  state_t           state_q;
  logic [LSIZE-1:0] line_beats_q, line_num_q;
  logic [LSIZE-1:0] bcnt_q, lcnt_q;
  logic [SW-1:0]    settle_q;
  logic             new_base_q, burst_done_q, tail_done_q;
  logic             cmd_valid_q, frame_done_q, busy_q;
  logic [ASIZE-1:0] cmd_addr_q;
  logic [7:0]       cmd_len_q;

  // Line split derived from the latched line length (BURST_LEN is a power of two).
  logic [LSIZE-1:0] nfull, rem, bursts_per_line;
  logic             last_burst, last_line;
  logic [7:0]       cmd_len_d;

  assign nfull           = line_beats_q >> BL_W;
  assign rem             = line_beats_q & LSIZE'(BURST_LEN - 1);
  assign bursts_per_line = nfull + ((rem != '0) ? LSIZE'(1) : LSIZE'(0));
  assign last_burst      = (bcnt_q == bursts_per_line - LSIZE'(1));
  assign last_line       = (lcnt_q == line_num_q - LSIZE'(1));
  assign cmd_len_d       = (last_burst && rem != '0) ? 8'(rem - LSIZE'(1))
                                                     : 8'(BURST_LEN - 1);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_beats_q <= '0;
      line_num_q   <= '0;
      bcnt_q       <= '0;
      lcnt_q       <= '0;
      settle_q     <= '0;
      new_base_q   <= 1'b0;
      burst_done_q <= 1'b0;
      tail_done_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            line_beats_q <= line_beats;
            line_num_q   <= line_num;
            bcnt_q       <= '0;
            lcnt_q       <= '0;
            new_base_q   <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          new_base_q <= 1'b0;
          settle_q   <= '0;
          if (line_beats_q == '0 || line_num_q == '0) begin
            frame_done_q <= 1'b1;
            state_q      <= S_FEND;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // Address is sampled only once the generator has had time to react to the strobe.
          if (settle_q == SETTLE_LAST) begin
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= addr_in;
            cmd_len_q   <= cmd_len_d;
            state_q     <= S_ISSUE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (burst_resp_done) begin
            tail_done_q  <= last_burst;
            burst_done_q <= !last_burst;
            state_q      <= S_ADV;
          end
        end
        S_ADV: begin
          burst_done_q <= 1'b0;
          tail_done_q  <= 1'b0;
          settle_q     <= '0;
          if (last_burst && last_line) begin
            frame_done_q <= 1'b1;
            state_q      <= S_FEND;
          end else if (last_burst) begin
            bcnt_q  <= '0;
            lcnt_q  <= lcnt_q + LSIZE'(1);
            state_q <= S_SETTLE;
          end else begin
            bcnt_q  <= bcnt_q + LSIZE'(1);
            state_q <= S_SETTLE;
          end
        end
        S_FEND: begin
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign new_base   = new_base_q;
  assign burst_done = burst_done_q;
  assign tail_done  = tail_done_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vdma_burst_sched.sv
// Directed bench for vdma_burst_sched: outputs sampled and inputs driven on the falling edge,
// with the address generator emulated by bumping addr_in after every strobe.
module tb_vdma_burst_sched;

  logic        clock = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] line_beats, line_num;
  logic [28:0] addr_in;
  logic        new_base, burst_done, tail_done, cmd_valid, cmd_ready;
  logic [28:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        burst_resp_done, frame_done, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int nb_count = 0;

  vdma_burst_sched #(.ASIZE(29), .LSIZE(16), .BURST_LEN(256), .ADDR_SETTLE(4)) dut (
    .clock(clock), .rst(rst), .frame_start(frame_start), .line_beats(line_beats),
    .line_num(line_num), .addr_in(addr_in), .new_base(new_base), .burst_done(burst_done),
    .tail_done(tail_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .burst_resp_done(burst_resp_done), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (new_base) nb_count++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic [15:0] beats, input logic [15:0] lines);
    line_beats  = beats;
    line_num    = lines;
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    n_tests++;
    if (new_base !== 1'b1 || busy !== 1'b1 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency: new_base=%b busy=%b cmd_valid=%b, expected 1 1 0",
               new_base, busy, cmd_valid);
    end
    addr_in = addr_in + 29'h0001000;
  endtask

  // Serves one burst from the strobe that preceded it up to its own done strobe.
  task automatic run_burst(input logic [7:0] exp_len, input bit exp_tail, input int exp_lat,
                           input int stall, input bit stray, input bit resp_at_accept);
    int n = 0;
    int bad = 0;
    logic [28:0] exp_addr;
    do begin
      @(negedge clock);
      n++;
    end while (cmd_valid !== 1'b1 && n < 20);
    n_tests++;
    if (n != exp_lat || cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_latency: got %0d cycles (valid=%b), expected %0d", n, cmd_valid, exp_lat);
    end
    exp_addr = addr_in;
    n_tests++;
    if (cmd_len !== exp_len || cmd_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL cmd_fields: len=%0d addr=%h, expected len=%0d addr=%h",
               cmd_len, cmd_addr, exp_len, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      if (stray) begin
        frame_start     = (i == 0);
        burst_resp_done = (i == 0);
        line_beats      = 16'd5;
      end
      addr_in = addr_in ^ 29'h0155;
      @(negedge clock);
      if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr || cmd_len !== exp_len ||
          burst_done !== 1'b0 || tail_done !== 1'b0 || new_base !== 1'b0) bad++;
    end
    frame_start     = 1'b0;
    burst_resp_done = 1'b0;
    if (stall > 0) begin
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL stall_stable: %0d unstable cycles, expected 0", bad);
      end
    end
    cmd_ready       = 1'b1;
    burst_resp_done = resp_at_accept;
    @(negedge clock);
    cmd_ready       = 1'b0;
    burst_resp_done = 1'b0;
    n_tests++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept: cmd_valid=%b after handshake, expected 0", cmd_valid);
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (burst_done !== 1'b0 || tail_done !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_quiet: burst_done=%b tail_done=%b valid=%b, expected 0 0 0",
               burst_done, tail_done, cmd_valid);
    end
    burst_resp_done = 1'b1;
    @(negedge clock);
    burst_resp_done = 1'b0;
    n_tests++;
    if (burst_done !== !exp_tail || tail_done !== exp_tail || new_base !== 1'b0) begin
      n_fail++;
      $display("FAIL done_strobe: burst_done=%b tail_done=%b new_base=%b, expected %b %b 0",
               burst_done, tail_done, new_base, !exp_tail, exp_tail);
    end
    addr_in = addr_in + 29'h0000100;
  endtask

  task automatic expect_frame_end();
    @(negedge clock);
    n_tests++;
    if (frame_done !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done: frame_done=%b busy=%b, expected 1 1", frame_done, busy);
    end
    @(negedge clock);
    n_tests++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_idle: frame_done=%b busy=%b, expected 0 0", frame_done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({new_base, burst_done, tail_done, cmd_valid, frame_done, busy} !== 6'b0 ||
        cmd_addr !== 29'h0 || cmd_len !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: strobes=%b addr=%h len=%0d, expected all 0",
               {new_base, burst_done, tail_done, cmd_valid, frame_done, busy}, cmd_addr, cmd_len);
    end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_tail_line();
    start_frame(16'd600, 16'd1);
    run_burst(8'd255, 1'b0, 5, 0, 1'b0, 1'b0);
    run_burst(8'd255, 1'b0, 5, 0, 1'b0, 1'b0);
    run_burst(8'd87,  1'b1, 5, 0, 1'b0, 1'b0);
    expect_frame_end();
  endtask

  task automatic test_back_to_back();
    int nb0;
    nb0 = nb_count;
    start_frame(16'd512, 16'd3);
    for (int l = 0; l < 3; l++) begin
      run_burst(8'd255, 1'b0, 5, 0, 1'b0, 1'b0);
      run_burst(8'd255, 1'b1, 5, 0, 1'b0, 1'b0);
    end
    expect_frame_end();
    n_tests++;
    if (nb_count - nb0 != 1) begin
      n_fail++;
      $display("FAIL new_base_count: got %0d pulses, expected 1", nb_count - nb0);
    end
  endtask

  task automatic test_empty_frame();
    start_frame(16'd0, 16'd5);
    @(negedge clock);
    n_tests++;
    if (frame_done !== 1'b1 || cmd_valid !== 1'b0 || new_base !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_beats: frame_done=%b valid=%b new_base=%b, expected 1 0 0",
               frame_done, cmd_valid, new_base);
    end
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || new_base !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_fend: busy=%b new_base=%b frame_done=%b, expected 0 0 0",
               busy, new_base, frame_done);
    end
    start_frame(16'd300, 16'd0);
    @(negedge clock);
    n_tests++;
    if (frame_done !== 1'b1 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_lines: frame_done=%b valid=%b, expected 1 0", frame_done, cmd_valid);
    end
    @(negedge clock);
  endtask

  task automatic test_stall();
    start_frame(16'd100, 16'd1);
    run_burst(8'd99, 1'b1, 5, 10, 1'b0, 1'b1);
    expect_frame_end();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start_frame(16'd600, 16'd2);
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready       = 1'b0;
    rst             = 1'b1;
    burst_resp_done = 1'b1;
    @(negedge clock);
    burst_resp_done = 1'b0;
    rst             = 1'b0;
    n_tests++;
    if ({new_base, burst_done, tail_done, cmd_valid, frame_done, busy} !== 6'b0 ||
        cmd_addr !== 29'h0 || cmd_len !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid: strobes=%b addr=%h len=%0d, expected all 0",
               {new_base, burst_done, tail_done, cmd_valid, frame_done, busy}, cmd_addr, cmd_len);
    end
    @(negedge clock);
    n_tests++;
    if ({burst_done, tail_done, frame_done, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_after: strobes=%b, expected 0000",
               {burst_done, tail_done, frame_done, busy});
    end
    start_frame(16'd300, 16'd1);
    run_burst(8'd255, 1'b0, 5, 0, 1'b0, 1'b0);
    run_burst(8'd43,  1'b1, 5, 0, 1'b0, 1'b0);
    expect_frame_end();
  endtask

  task automatic test_stray_inputs();
    start_frame(16'd600, 16'd1);
    line_beats      = 16'd7;
    line_num        = 16'd9;
    burst_resp_done = 1'b1;
    frame_start     = 1'b1;
    @(negedge clock);
    burst_resp_done = 1'b0;
    frame_start     = 1'b0;
    run_burst(8'd255, 1'b0, 4, 3, 1'b1, 1'b0);
    run_burst(8'd255, 1'b0, 5, 0, 1'b0, 1'b0);
    run_burst(8'd87,  1'b1, 5, 0, 1'b0, 1'b0);
    expect_frame_end();
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; line_beats = '0; line_num = '0;
    addr_in = 29'h0100000; cmd_ready = 1'b0; burst_resp_done = 1'b0;
    test_reset();
    test_tail_line();
    test_back_to_back();
    test_empty_frame();
    test_stall();
    test_reset_mid();
    test_stray_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
